// File: rtl/zsram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zsram_pkg
// Brief    : Shared types, default sizing/timing and the address decoder.
// Revision : 1.0
// ============================================================================
package zsram_pkg;

  localparam int ZSRAM_WIDTH     = 8;
  localparam int ZSRAM_DEPTH     = 16;
  localparam int ZSRAM_SETUP_CYC = 1;
  localparam int ZSRAM_PULSE_CYC = 2;
  localparam int ZSRAM_HOLD_CYC  = 1;
  // Upper bound on DEPTH the decoder below can serve.
  localparam int ZSRAM_MAX_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } zsram_state_e;

  // Out-of-range addresses decode to all zeros, so they can never strobe a word.
  function automatic logic [ZSRAM_MAX_DEPTH-1:0] addr_to_onehot(
    input int unsigned addr,
    input int unsigned depth
  );
    logic [ZSRAM_MAX_DEPTH-1:0] onehot;
    onehot = '0;
    for (int unsigned i = 0; i < ZSRAM_MAX_DEPTH; i++) begin
      if ((i < depth) && (i == addr)) onehot[i] = 1'b1;
    end
    return onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zsram_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : zsram_phase_timer
// Brief    : Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
// Revision : 1.0
// ============================================================================
module zsram_phase_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/zsram_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : zsram_access_controller
// Brief    : Host-side sequencer driving setup/strobe/hold timing into a ZSRAM
//            cell array, one outstanding access with a registered response.
// Revision : 1.0
// ============================================================================
module zsram_access_controller
  import zsram_pkg::*;
#(
  parameter  int WIDTH     = ZSRAM_WIDTH,
  parameter  int DEPTH     = ZSRAM_DEPTH,
  parameter  int SETUP_CYC = ZSRAM_SETUP_CYC,
  parameter  int PULSE_CYC = ZSRAM_PULSE_CYC,
  parameter  int HOLD_CYC  = ZSRAM_HOLD_CYC,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             Crystal50Mhz,
  input  logic             ResetLow,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqWrite,
  input  logic [AW-1:0]    ReqAddr,
  input  logic [WIDTH-1:0] ReqWData,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic             RspWrite,
  output logic             RspError,
  output logic [DEPTH-1:0] WriteEdge,
  output logic [DEPTH-1:0] ReadEdge,
  output logic [WIDTH-1:0] CellInputData,
  input  logic [WIDTH-1:0] CellOutputData,
  output logic             Busy
);

  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LOAD = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] PULSE_LOAD = CW'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYC  > 0) ? HOLD_CYC  - 1 : 0);

  if (PULSE_CYC < 1) begin : g_pulse_check
    $error("zsram_access_controller: PULSE_CYC must be at least 1");
  end
  if ((DEPTH < 2) || (DEPTH > ZSRAM_MAX_DEPTH)) begin : g_depth_check
    $error("zsram_access_controller: DEPTH out of supported range");
  end

  zsram_state_e    state;
  zsram_state_e    state_next;
  logic            op_write;
  logic [AW-1:0]   op_addr;
  logic            timer_load;
  logic [CW-1:0]   timer_load_value;
  logic            timer_done;
  logic            req_accept;
  logic            rsp_accept;
  logic            addr_err;
  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [DEPTH-1:0] strobe_sel;

  assign req_accept = ReqValid && ReqReady;
  assign rsp_accept = RspValid && RspReady;
  assign addr_err   = ({1'b0, ReqAddr} >= (AW+1)'(DEPTH));

  // The strobe for an access entering PULSE straight from IDLE must come from
  // the request itself, since the latched copy is not yet valid.
  assign cur_write  = (state == ST_IDLE) ? ReqWrite : op_write;
  assign cur_addr   = (state == ST_IDLE) ? ReqAddr  : op_addr;
  assign strobe_sel = DEPTH'(addr_to_onehot(32'(cur_addr), DEPTH));

  zsram_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk        (Crystal50Mhz),
    .rst_n      (ResetLow),
    .load       (timer_load),
    .load_value (timer_load_value),
    .done       (timer_done)
  );

  always_comb begin
    state_next       = state;
    timer_load       = 1'b0;
    timer_load_value = '0;

    case (state)
      ST_IDLE: begin
        if (req_accept) begin
          if (addr_err)           state_next = ST_RESP;
          else if (SETUP_CYC > 0) state_next = ST_SETUP;
          else                    state_next = ST_PULSE;
        end
      end
      ST_SETUP: if (timer_done) state_next = ST_PULSE;
      ST_PULSE: if (timer_done) state_next = (HOLD_CYC > 0) ? ST_HOLD : ST_RESP;
      ST_HOLD:  if (timer_done) state_next = ST_RESP;
      ST_RESP:  if (rsp_accept) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (state_next != state) begin
      case (state_next)
        ST_SETUP: begin timer_load = 1'b1; timer_load_value = SETUP_LOAD; end
        ST_PULSE: begin timer_load = 1'b1; timer_load_value = PULSE_LOAD; end
        ST_HOLD:  begin timer_load = 1'b1; timer_load_value = HOLD_LOAD;  end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Crystal50Mhz or negedge ResetLow) begin
    if (!ResetLow) begin
      state         <= ST_IDLE;
      op_write      <= 1'b0;
      op_addr       <= '0;
      ReqReady      <= 1'b0;
      RspValid      <= 1'b0;
      RspData       <= '0;
      RspWrite      <= 1'b0;
      RspError      <= 1'b0;
      WriteEdge     <= '0;
      ReadEdge      <= '0;
      CellInputData <= '0;
      Busy          <= 1'b0;
    end else begin
      state    <= state_next;
      ReqReady <= (state_next == ST_IDLE);
      Busy     <= (state_next != ST_IDLE);

      WriteEdge <= ((state_next == ST_PULSE) &&  cur_write) ? strobe_sel : '0;
      ReadEdge  <= ((state_next == ST_PULSE) && !cur_write) ? strobe_sel : '0;

      if (req_accept) begin
        op_write      <= ReqWrite;
        op_addr       <= ReqAddr;
        CellInputData <= (ReqWrite && !addr_err) ? ReqWData : '0;
        RspData       <= '0;
        RspWrite      <= ReqWrite;
        RspError      <= addr_err;
      end

      // Read data is captured on the edge that closes the final PULSE cycle.
      if ((state == ST_PULSE) && timer_done && !op_write) begin
        RspData <= CellOutputData;
      end

      // Error responses enter RESP from IDLE and raise RspValid one edge later.
      if ((state == ST_RESP) && rsp_accept) begin
        RspValid      <= 1'b0;
        RspData       <= '0;
        RspWrite      <= 1'b0;
        RspError      <= 1'b0;
        CellInputData <= '0;
      end else if (((state_next == ST_RESP) && (state != ST_IDLE)) || (state == ST_RESP)) begin
        RspValid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zsram_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_zsram_access_controller
// Brief    : Directed bench for the default build and a DEPTH=12, 0/1/0 build.
// Revision : 1.0
// ============================================================================
module tb_zsram_access_controller;

  logic        clk;
  logic        rst_n;
  logic        req_valid_d;
  logic        req_valid_a;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_ready;

  logic        d_ready, d_valid, d_rwrite, d_rerr, d_busy;
  logic [7:0]  d_rdata, d_cin, d_cout;
  logic [15:0] d_we, d_re;

  logic        a_ready, a_valid, a_rwrite, a_rerr, a_busy;
  logic [7:0]  a_rdata, a_cin, a_cout;
  logic [11:0] a_we, a_re;

  int n_run  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zsram_access_controller u_dut (
    .Crystal50Mhz   (clk),
    .ResetLow       (rst_n),
    .ReqValid       (req_valid_d),
    .ReqReady       (d_ready),
    .ReqWrite       (req_write),
    .ReqAddr        (req_addr),
    .ReqWData       (req_wdata),
    .RspValid       (d_valid),
    .RspReady       (rsp_ready),
    .RspData        (d_rdata),
    .RspWrite       (d_rwrite),
    .RspError       (d_rerr),
    .WriteEdge      (d_we),
    .ReadEdge       (d_re),
    .CellInputData  (d_cin),
    .CellOutputData (d_cout),
    .Busy           (d_busy)
  );

  zsram_access_controller #(
    .WIDTH(8), .DEPTH(12), .SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)
  ) u_alt (
    .Crystal50Mhz   (clk),
    .ResetLow       (rst_n),
    .ReqValid       (req_valid_a),
    .ReqReady       (a_ready),
    .ReqWrite       (req_write),
    .ReqAddr        (req_addr),
    .ReqWData       (req_wdata),
    .RspValid       (a_valid),
    .RspReady       (rsp_ready),
    .RspData        (a_rdata),
    .RspWrite       (a_rwrite),
    .RspError       (a_rerr),
    .WriteEdge      (a_we),
    .ReadEdge       (a_re),
    .CellInputData  (a_cin),
    .CellOutputData (a_cout),
    .Busy           (a_busy)
  );

  // Cell array model for the default build; unwritten words read as 0x3C.
  logic [7:0]  cell_mem [16];
  logic [15:0] written;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (d_we[i]) begin
          cell_mem[i] <= d_cin;
          written[i]  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    d_cout = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      if (d_re[i]) d_cout = written[i] ? cell_mem[i] : 8'h3C;
    end
  end

  assign a_cout = (|a_re) ? 8'h5A : 8'hFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          obs_lat, obs_first, obs_npulse;
  logic [15:0] obs_strobe;
  logic        obs_wrong_bus, obs_rwrite, obs_rerr;
  logic [7:0]  obs_cin1, obs_rdata;

  // Issues one request at a negedge and watches until the response appears.
  task automatic access(input bit alt, input logic wr, input logic [3:0] a, input logic [7:0] wd);
    logic [15:0] we, re, sel;
    req_write = wr; req_addr = a; req_wdata = wd;
    if (alt) req_valid_a = 1'b1; else req_valid_d = 1'b1;
    obs_lat = -1; obs_first = -1; obs_npulse = 0; obs_strobe = '0;
    obs_wrong_bus = 1'b0; obs_cin1 = '0; obs_rdata = '0; obs_rwrite = 1'b0; obs_rerr = 1'b0;
    for (int cyc = 1; (cyc <= 20) && (obs_lat < 0); cyc++) begin
      @(negedge clk);
      req_valid_d = 1'b0;
      req_valid_a = 1'b0;
      we  = alt ? {4'b0, a_we} : d_we;
      re  = alt ? {4'b0, a_re} : d_re;
      sel = wr ? we : re;
      if (cyc == 1) obs_cin1 = alt ? a_cin : d_cin;
      if ((wr ? re : we) != '0) obs_wrong_bus = 1'b1;
      if (sel != '0) begin
        if (obs_first < 0) obs_first = cyc - 1;
        obs_npulse++;
        obs_strobe = obs_strobe | sel;
      end
      if (alt ? a_valid : d_valid) begin
        obs_lat    = cyc - 1;
        obs_rdata  = alt ? a_rdata  : d_rdata;
        obs_rwrite = alt ? a_rwrite : d_rwrite;
        obs_rerr   = alt ? a_rerr   : d_rerr;
      end
    end
  endtask

  task automatic accept_rsp(input bit alt, input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(alt ? a_valid : d_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(alt ? a_ready : d_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic stable;
    rst_n = 1'b0; req_valid_d = 1'b0; req_valid_a = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_d_outs", 32'(d_ready | d_valid | d_busy | d_rwrite | d_rerr |
                             (|d_rdata) | (|d_we) | (|d_re) | (|d_cin)), 32'd0);
    check("rst_a_outs", 32'(a_ready | a_valid | a_busy | a_rwrite | a_rerr |
                             (|a_rdata) | (|a_we) | (|a_re) | (|a_cin)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'({d_ready, d_busy, a_ready, a_busy}), 32'b1010);

    // Write 0xA5 to word 5 with default timing.
    access(1'b0, 1'b1, 4'd5, 8'hA5);
    check("wr_lat",     32'(obs_lat),       32'd4);
    check("wr_first",   32'(obs_first),     32'd1);
    check("wr_npulse",  32'(obs_npulse),    32'd2);
    check("wr_strobe",  32'(obs_strobe),    32'h0020);
    check("wr_bus",     32'(obs_wrong_bus), 32'd0);
    check("wr_cin",     32'(obs_cin1),      32'hA5);
    check("wr_rsp",     32'({obs_rdata, obs_rwrite, obs_rerr}), 32'({8'h00, 1'b1, 1'b0}));

    // Response back-pressure: fields stay put and new requests are refused.
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid_d = 1'b1;
      req_write = i[0];
      req_addr = 4'(i);
      @(negedge clk);
      if (d_valid !== 1'b1 || d_rwrite !== 1'b1 || d_rdata !== 8'h00 || d_rerr !== 1'b0 ||
          d_ready !== 1'b0 || d_busy !== 1'b1 || d_we !== '0 || d_re !== '0 || d_cin !== 8'hA5)
        stable = 1'b0;
    end
    req_valid_d = 1'b0;
    check("bp_stable", 32'(stable), 32'd1);
    accept_rsp(1'b0, "wr");
    @(negedge clk);
    check("bp_no_accept", 32'(d_busy), 32'd0);

    // Read the written word back, then an untouched word.
    access(1'b0, 1'b0, 4'd5, 8'h00);
    check("rd5_lat",    32'(obs_lat),       32'd4);
    check("rd5_strobe", 32'(obs_strobe),    32'h0020);
    check("rd5_npulse", 32'(obs_npulse),    32'd2);
    check("rd5_bus",    32'(obs_wrong_bus), 32'd0);
    check("rd5_cin",    32'(obs_cin1),      32'h00);
    check("rd5_rsp",    32'({obs_rdata, obs_rwrite, obs_rerr}), 32'({8'hA5, 1'b0, 1'b0}));
    accept_rsp(1'b0, "rd5");

    access(1'b0, 1'b0, 4'd9, 8'h00);
    check("rd9_strobe", 32'(obs_strobe), 32'h0200);
    check("rd9_rsp",    32'({obs_rdata, obs_rwrite, obs_rerr}), 32'({8'h3C, 1'b0, 1'b0}));
    accept_rsp(1'b0, "rd9");

    // Reset lands during the first PULSE cycle of a write.
    req_write = 1'b1; req_addr = 4'd3; req_wdata = 8'h77; req_valid_d = 1'b1;
    @(negedge clk);
    req_valid_d = 1'b0;
    @(negedge clk);
    check("mid_strobe", 32'(d_we), 32'h0008);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", 32'({d_we, d_cin, d_busy, d_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (d_valid !== 1'b0 || d_busy !== 1'b0) stable = 1'b0;
    end
    check("no_stale_rsp", 32'(stable), 32'd1);
    access(1'b0, 1'b0, 4'd3, 8'h00);
    check("post_rst_lat", 32'(obs_lat), 32'd4);
    check("post_rst_rsp", 32'({obs_rdata, obs_rwrite, obs_rerr}), 32'({8'h3C, 1'b0, 1'b0}));
    accept_rsp(1'b0, "post_rst");

    // DEPTH=12, zero setup/hold, single-cycle pulse.
    access(1'b1, 1'b1, 4'd2, 8'h11);
    check("alt_wr_lat",    32'(obs_lat),    32'd1);
    check("alt_wr_first",  32'(obs_first),  32'd0);
    check("alt_wr_npulse", 32'(obs_npulse), 32'd1);
    check("alt_wr_strobe", 32'(obs_strobe), 32'h0004);
    check("alt_wr_cin",    32'(obs_cin1),   32'h11);
    accept_rsp(1'b1, "alt_wr");

    access(1'b1, 1'b0, 4'd11, 8'h00);
    check("alt_rd11_strobe", 32'(obs_strobe), 32'h0800);
    check("alt_rd11_rsp", 32'({obs_rdata, obs_rwrite, obs_rerr, 4'(obs_lat)}),
          32'({8'h5A, 1'b0, 1'b0, 4'd1}));
    accept_rsp(1'b1, "alt_rd11");

    access(1'b1, 1'b0, 4'd13, 8'h00);
    check("err13_strobe", 32'({obs_npulse[3:0], obs_strobe, obs_wrong_bus}), 32'd0);
    check("err13_rsp", 32'({obs_rdata, obs_rwrite, obs_rerr, 4'(obs_lat)}),
          32'({8'h00, 1'b0, 1'b1, 4'd1}));
    accept_rsp(1'b1, "err13");

    access(1'b1, 1'b1, 4'd12, 8'hC3);
    check("err12_strobe", 32'({obs_npulse[3:0], obs_strobe, obs_wrong_bus}), 32'd0);
    check("err12_rsp", 32'({obs_rdata, obs_rwrite, obs_rerr, 4'(obs_lat)}),
          32'({8'h00, 1'b1, 1'b1, 4'd1}));
    accept_rsp(1'b1, "err12");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
